// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: datapath <-> main control bundle of the multi-cycle MIPS core
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pc_we;
  logic        ir_we;
  logic        reg_we;
  logic        mem_we;
  logic        mem_re;
  logic [1:0]  ext_op;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic [1:0]  reg_dst;
  logic [1:0]  wd_sel;
  logic [1:0]  npc_sel;
  logic [2:0]  state;
  logic        illegal;
  modport master (
    input  instr, zero, mem_ready,
    output pc_we, ir_we, reg_we, mem_we, mem_re, ext_op, alu_op, alu_src,
           reg_dst, wd_sel, npc_sel, state, illegal
  );
  modport slave (
    output instr, zero, mem_ready,
    input  pc_we, ir_we, reg_we, mem_we, mem_re, ext_op, alu_op, alu_src,
           reg_dst, wd_sel, npc_sel, state, illegal
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: FETCH/DECODE/EXEC/MEM/WB control FSM of the multi-cycle MIPS core
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t        st;
  logic [CW-1:0] cnt;
  logic          ill;
  logic [5:0]    op, fn;
  logic          is_r, is_add, is_sub, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, legal;
  assign op     = bus.instr[31:26];
  assign fn     = bus.instr[5:0];
  assign is_r   = op == 6'h00;
  assign is_add = is_r && fn == 6'h20;
  assign is_sub = is_r && fn == 6'h22;
  assign is_jr  = is_r && fn == 6'h08;
  assign is_ori = op == 6'h0d;
  assign is_lui = op == 6'h0f;
  assign is_lw  = op == 6'h23;
  assign is_sw  = op == 6'h2b;
  assign is_beq = op == 6'h04;
  assign is_j   = op == 6'h02;
  assign is_jal = op == 6'h03;
  assign legal  = is_add | is_sub | is_jr | is_ori | is_lui | is_lw | is_sw | is_beq | is_j | is_jal;
  assign bus.state   = st;
  assign bus.illegal = ill;
  // State sequencing, MEM wait counter and sticky illegal flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st  <= FETCH;
      cnt <= '0;
      ill <= 1'b0;
    end else begin
      case (st)
        FETCH:  st <= DECODE;
        DECODE: begin
          if (!legal) ill <= 1'b1;
          st <= (!legal || is_j || is_jr || is_jal) ? FETCH : EXEC;
        end
        EXEC: begin
          cnt <= '0;
          st  <= (is_lw || is_sw) ? MEM : is_beq ? FETCH : WB;
        end
        MEM: begin
          if (bus.mem_ready) st <= is_lw ? WB : FETCH;
          else if (cnt == CW'(MEM_TIMEOUT - 1)) begin
            ill <= 1'b1;
            st  <= FETCH;
          end else cnt <= cnt + 1'b1;
        end
        default: st <= FETCH;
      endcase
    end
  end
  // Moore decode per state and instruction class; everything forced low while reset is held
  always_comb begin
    bus.pc_we   = 1'b0;
    bus.ir_we   = 1'b0;
    bus.reg_we  = 1'b0;
    bus.mem_we  = 1'b0;
    bus.mem_re  = 1'b0;
    bus.ext_op  = 2'b00;
    bus.alu_op  = 3'b000;
    bus.alu_src = 1'b0;
    bus.reg_dst = 2'b00;
    bus.wd_sel  = 2'b00;
    bus.npc_sel = 2'b00;
    if (!reset) begin
      case (st)
        FETCH: begin
          bus.ir_we = 1'b1;
          bus.pc_we = 1'b1;
        end
        DECODE: begin
          bus.pc_we   = is_j | is_jr | is_jal;
          bus.reg_we  = is_jal;
          bus.npc_sel = is_jr ? 2'b11 : (is_j || is_jal) ? 2'b10 : 2'b00;
          bus.reg_dst = is_jal ? 2'b10 : 2'b00;
          bus.wd_sel  = is_jal ? 2'b10 : 2'b00;
        end
        EXEC: begin
          bus.pc_we   = is_beq & bus.zero;
          bus.npc_sel = is_beq ? 2'b01 : 2'b00;
        end
        MEM: begin
          bus.mem_re = is_lw;
          bus.mem_we = is_sw;
        end
        WB: begin
          bus.reg_we  = 1'b1;
          bus.reg_dst = is_r ? 2'b01 : 2'b00;
          bus.wd_sel  = is_lw ? 2'b01 : 2'b00;
        end
        default: ;
      endcase
      if (st != FETCH) begin
        bus.ext_op  = is_ori ? 2'b01 : is_lui ? 2'b10 : 2'b00;
        bus.alu_op  = (is_sub || is_beq) ? 3'b001 : (is_ori || is_lui) ? 3'b010 : 3'b000;
        bus.alu_src = is_ori | is_lui | is_lw | is_sw;
      end
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of the mc_ctrl sequencing and control outputs
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total = 0;
  mc_ctrl_if bus ();
  mc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  // Starts in FETCH, loads ins, returns cycles until FETCH is reached again (bounded)
  task automatic run_count(input logic [31:0] ins, output int n);
    bus.instr = ins;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.state != 3'd0 && n < 64);
  endtask
  logic [31:0] tbl_ins [6] = '{32'h08000000, 32'h03E00008, 32'h00221820, 32'h3C011234, 32'hAC020000, 32'h8C020000};
  int          tbl_cyc [6] = '{2, 2, 4, 4, 4, 5};
  string       tbl_tag [6] = '{"j_cycles", "jr_cycles", "add_cycles", "lui_cycles", "sw_cycles", "lw_cycles"};
  initial begin
    int n, k;
    reset = 1'b1;
    bus.instr = 32'h0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) step();
    chk("rst_state", bus.state, 0);
    chk("rst_pc_we", bus.pc_we, 0);
    chk("rst_ir_we", bus.ir_we, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_ext_op", bus.ext_op, 0);
    reset = 1'b0;
    #1 chk("fetch_ir_we", bus.ir_we, 1);
    chk("fetch_pc_we", bus.pc_we, 1);
    chk("fetch_npc_sel", bus.npc_sel, 0);
    bus.instr = 32'h3401FFFF;
    step();
    chk("ori_dec_state", bus.state, 1);
    chk("ori_dec_ext", bus.ext_op, 1);
    step();
    chk("ori_exec_state", bus.state, 2);
    chk("ori_exec_ext", bus.ext_op, 1);
    chk("ori_exec_src", bus.alu_src, 1);
    chk("ori_exec_alu", bus.alu_op, 2);
    step();
    chk("ori_wb_state", bus.state, 4);
    chk("ori_wb_reg_we", bus.reg_we, 1);
    chk("ori_wb_reg_dst", bus.reg_dst, 0);
    chk("ori_wb_ext", bus.ext_op, 1);
    step();
    chk("ori_done", bus.state, 0);
    bus.instr = 32'h8C020000;
    bus.mem_ready = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) begin
      chk("lw_mem_state", bus.state, 3);
      chk("lw_mem_re", bus.mem_re, 1);
      if (i == 3) bus.mem_ready = 1'b1;
      step();
    end
    chk("lw_wb_state", bus.state, 4);
    chk("lw_wb_wd_sel", bus.wd_sel, 1);
    chk("lw_wb_reg_we", bus.reg_we, 1);
    step();
    chk("lw_done", bus.state, 0);
    for (int z = 1; z >= 0; z--) begin
      bus.instr = 32'h10000000;
      bus.zero = z[0];
      repeat (2) step();
      chk("beq_exec_state", bus.state, 2);
      chk("beq_pc_we", bus.pc_we, z);
      chk("beq_npc_sel", bus.npc_sel, 1);
      chk("beq_alu_op", bus.alu_op, 1);
      step();
      chk("beq_done", bus.state, 0);
    end
    bus.instr = 32'h0C000000;
    step();
    chk("jal_reg_dst", bus.reg_dst, 2);
    chk("jal_wd_sel", bus.wd_sel, 2);
    chk("jal_reg_we", bus.reg_we, 1);
    chk("jal_npc_sel", bus.npc_sel, 2);
    chk("jal_pc_we", bus.pc_we, 1);
    step();
    chk("jal_done", bus.state, 0);
    bus.instr = 32'h00221822;
    repeat (2) step();
    chk("sub_alu_op", bus.alu_op, 1);
    chk("sub_alu_src", bus.alu_src, 0);
    step();
    chk("sub_wb_reg_dst", bus.reg_dst, 1);
    chk("sub_wb_wd_sel", bus.wd_sel, 0);
    step();
    for (int i = 0; i < 6; i++) begin
      run_count(tbl_ins[i], n);
      chk(tbl_tag[i], n, tbl_cyc[i]);
    end
    bus.instr = 32'h00221820;
    repeat (2) step();
    chk("mid_exec_state", bus.state, 2);
    #2 reset = 1'b1;
    #1 chk("midrst_state", bus.state, 0);
    chk("midrst_reg_we", bus.reg_we, 0);
    chk("midrst_mem_we", bus.mem_we, 0);
    chk("midrst_pc_we", bus.pc_we, 0);
    chk("midrst_ir_we", bus.ir_we, 0);
    step();
    reset = 1'b0;
    #1 chk("midrst_fetch", bus.state, 0);
    step();
    chk("midrst_decode", bus.state, 1);
    repeat (3) step();
    chk("midrst_done", bus.state, 0);
    bus.instr = 32'hFC000000;
    step();
    chk("bad_dec_state", bus.state, 1);
    chk("bad_dec_illegal", bus.illegal, 0);
    step();
    chk("bad_fetch", bus.state, 0);
    chk("bad_illegal", bus.illegal, 1);
    bus.instr = 32'hAC020000;
    bus.mem_ready = 1'b0;
    repeat (3) step();
    n = 0;
    k = 0;
    while (bus.state == 3'd3 && n < 40) begin
      n++;
      if (bus.mem_we) k++;
      step();
    end
    chk("sw_to_mem_cycles", n, 16);
    chk("sw_to_mem_we_cycles", k, 16);
    chk("sw_to_state", bus.state, 0);
    chk("sw_to_illegal", bus.illegal, 1);
    chk("sw_to_reg_we", bus.reg_we, 0);
    step();
    chk("sw_to_dec_mem_we", bus.mem_we, 0);
    chk("sw_to_dec_reg_we", bus.reg_we, 0);
    chk("ill_sticky", bus.illegal, 1);
    reset = 1'b1;
    #1 chk("ill_cleared", bus.illegal, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
